// File: rtl/adc_scan_sequencer_if.sv
// adc_scan_sequencer_if: SAR conversion handshake plus the result-FIFO read port.
// The sequencer connects through the master modport; the SAR model / register
// block side uses the slave modport.
interface adc_scan_sequencer_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        channel_sel;
  logic [1:0]        pga_gain;
  logic              start_conv;
  logic              sar_busy;
  logic              sar_valid;
  logic [DATA_W-1:0] sar_data;
  logic              fifo_rd;
  logic [DATA_W+1:0] fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    output channel_sel, pga_gain, start_conv,
    output fifo_rdata, fifo_empty, fifo_full, fifo_level,
    input  sar_busy, sar_valid, sar_data, fifo_rd
  );

  modport slave (
    input  channel_sel, pga_gain, start_conv,
    input  fifo_rdata, fifo_empty, fifo_full, fifo_level,
    output sar_busy, sar_valid, sar_data, fifo_rd
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks the channel mask, drives mux/PGA, kicks the SAR and
// buffers tagged results in a show-ahead FIFO.
// Optional conversion watchdog: define ADC_SCAN_TIMEOUT_EN to build it in;
// without it WAIT_CONV waits indefinitely and timeout_err is tied low.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for scan_start with scan_en and a non-empty mask
// S_SELECT    | present channel/gain to mux and PGA, load settle counter
// S_SETTLE    | count settle time down to zero
// S_START     | hold off while SAR is busy, then issue one start_conv
// S_WAIT_CONV | wait for sar_valid rising edge, push result
// S_NEXT      | advance to next masked channel, end or restart the pass
module adc_scan_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 scan_en,
  input  logic                 scan_start,
  input  logic                 continuous,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [2*NUM_CH-1:0]  gain_cfg,
  input  logic [7:0]           settle_cycles,
  input  logic                 err_clr,
  adc_scan_sequencer_if.master bus,
  output logic                 scan_active,
  output logic                 scan_done,
  output logic                 overrun,
  output logic                 timeout_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_START, S_WAIT_CONV, S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [7:0]          settle_q, settle_d;
  logic [1:0]          chsel_q, chsel_d;
  logic [1:0]          gain_q, gain_d;
  logic                start_conv_q, start_conv_d;
  logic                scan_active_q, scan_active_d;
  logic                scan_done_q, scan_done_d;
  logic                sar_valid_q;
  logic                overrun_q, overrun_d;

  logic                sar_rise;
  logic                push;
  logic [2:0]          nxt;
  logic [1:0]          gain_sel;

  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [ENT_W-1:0]    rdata_q, rdata_d;
  logic                empty_q, empty_d, full_q, full_d;
  logic                pop, ovr_evt, do_push;

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                timeout_q, timeout_d;
  logic                tmo_evt;
`endif

  // Index of the lowest set bit of a mask (0 when the mask is empty).
  function automatic logic [1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [1:0] idx;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (m[k]) idx = 2'(k);
    return idx;
  endfunction

  // {found, index} of the next set bit strictly above cur.
  function automatic logic [2:0] next_set(input logic [NUM_CH-1:0] m, input logic [1:0] cur);
    logic [2:0] r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (m[k] && (k > int'(cur))) r = {1'b1, 2'(k)};
    return r;
  endfunction

  assign sar_rise = bus.sar_valid & ~sar_valid_q;
  assign nxt      = next_set(mask_q, ptr_q);

  // Gain field of the channel currently pointed at.
  always_comb begin
    gain_sel = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ptr_q == 2'(k)) gain_sel = gain_cfg[2*k +: 2];
  end

  // Scan FSM: next state, channel pointer, settle timer and output strobes.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    ptr_d        = ptr_q;
    settle_d     = settle_q;
    chsel_d      = chsel_q;
    gain_d       = gain_q;
    start_conv_d = 1'b0;
    scan_done_d  = 1'b0;
    push         = 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
    wd_d         = '0;
    tmo_evt      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (scan_start && scan_en && (|ch_mask)) begin
          mask_d  = ch_mask;
          ptr_d   = lowest_set(ch_mask);
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        chsel_d  = ptr_q;
        gain_d   = gain_sel;
        settle_d = settle_cycles;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == 8'd0) begin
          // The strobe is registered, so busy is looked at one cycle early.
          state_d      = S_START;
          start_conv_d = ~bus.sar_busy;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      S_START: begin
        if (start_conv_q) state_d = S_WAIT_CONV;
        else              start_conv_d = ~bus.sar_busy;
      end
      S_WAIT_CONV: begin
        if (sar_rise) begin
          push    = 1'b1;
          state_d = S_NEXT;
        end
`ifdef ADC_SCAN_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          tmo_evt = 1'b1;
          state_d = S_NEXT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_NEXT: begin
        if (nxt[2]) begin
          if (scan_en) begin
            ptr_d   = nxt[1:0];
            state_d = S_SELECT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          scan_done_d = 1'b1;
          if (continuous && scan_en) begin
            mask_d  = ch_mask;
            ptr_d   = lowest_set(ch_mask);
            state_d = (|ch_mask) ? S_SELECT : S_IDLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    scan_active_d = (state_d != S_IDLE);
  end

  // Result FIFO next state: pop before push so a full FIFO can swap in one cycle.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    pop     = bus.fifo_rd && (level_q != '0);
    ovr_evt = push && full_q && !bus.fifo_rd;
    do_push = push && !ovr_evt;
    if (pop) rd_d = rd_q + PTR_W'(1);
    if (do_push) begin
      mem_d[wr_q] = {ptr_q, bus.sar_data};
      wr_d        = wr_q + PTR_W'(1);
    end
    unique case ({do_push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_W'(FIFO_DEPTH));
    rdata_d = empty_d ? '0 : mem_d[rd_d];
  end

  // Sticky error flags: a new event in the clearing cycle keeps the flag set.
  always_comb begin
    overrun_d = ovr_evt ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
`ifdef ADC_SCAN_TIMEOUT_EN
    timeout_d = tmo_evt ? 1'b1 : (err_clr ? 1'b0 : timeout_q);
`endif
  end

  // Sequencer and FIFO control registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      ptr_q         <= '0;
      settle_q      <= '0;
      chsel_q       <= '0;
      gain_q        <= '0;
      start_conv_q  <= 1'b0;
      scan_active_q <= 1'b0;
      scan_done_q   <= 1'b0;
      sar_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      wr_q          <= '0;
      rd_q          <= '0;
      level_q       <= '0;
      rdata_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      ptr_q         <= ptr_d;
      settle_q      <= settle_d;
      chsel_q       <= chsel_d;
      gain_q        <= gain_d;
      start_conv_q  <= start_conv_d;
      scan_active_q <= scan_active_d;
      scan_done_q   <= scan_done_d;
      sar_valid_q   <= bus.sar_valid;
      overrun_q     <= overrun_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      level_q       <= level_d;
      rdata_q       <= rdata_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
    end
  end

  // FIFO storage; contents are don't-care while the level says empty.
  always_ff @(posedge PCLK) begin
    mem_q <= mem_d;
  end

`ifdef ADC_SCAN_TIMEOUT_EN
  // Watchdog counter and its sticky flag.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign bus.channel_sel = chsel_q;
  assign bus.pga_gain    = gain_q;
  assign bus.start_conv  = start_conv_q;
  assign bus.fifo_rdata  = rdata_q;
  assign bus.fifo_empty  = empty_q;
  assign bus.fifo_full   = full_q;
  assign bus.fifo_level  = level_q;
  assign scan_active     = scan_active_q;
  assign scan_done       = scan_done_q;
  assign overrun         = overrun_q;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: acts as SAR and FIFO reader, keeps a queue model
// of the result FIFO and error flags, and checks scan timing per conversion.
`timescale 1ns/1ps
module tb_adc_scan_sequencer;
  localparam int NUM_CH     = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int DATA_W     = 16;
`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 16;
`else
  localparam int TIMEOUT_CYC = 1024;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        scan_en, scan_start, continuous, err_clr;
  logic [2:0]  ch_mask;
  logic [5:0]  gain_cfg;
  logic [7:0]  settle_cycles;
  logic        scan_active, scan_done, overrun, timeout_err;

  adc_scan_sequencer_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  adc_scan_sequencer #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .scan_en(scan_en), .scan_start(scan_start),
    .continuous(continuous), .ch_mask(ch_mask), .gain_cfg(gain_cfg),
    .settle_cycles(settle_cycles), .err_clr(err_clr), .bus(bus),
    .scan_active(scan_active), .scan_done(scan_done), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int tmo_at = -1;

  // Model state: FIFO queue of {channel, data}, sticky flags.
  logic [17:0] m_q[$];
  bit          m_ovr, m_tmo, sv_prev, m_rise, m_pop;
  logic [1:0]  m_ch = 2'd0;
  bit          sc_prev, sd_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge PCLK) cyc <= cyc + 1;

  // Reference model: pops then pushes on each edge, as software would see it.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_q.delete();
      m_ovr   = 1'b0;
      m_tmo   = 1'b0;
      sv_prev = 1'b0;
    end else begin
      m_rise  = bus.sar_valid && !sv_prev;
      sv_prev = bus.sar_valid;
      m_pop   = bus.fifo_rd && (m_q.size() > 0);
      if (m_pop) void'(m_q.pop_front());
      if (m_rise) begin
        if (m_q.size() == FIFO_DEPTH) m_ovr = 1'b1;
        else m_q.push_back({m_ch, bus.sar_data});
      end else begin
        if (err_clr) m_ovr = 1'b0;
      end
      if (cyc == tmo_at) m_tmo = 1'b1;
      else if (err_clr) m_tmo = 1'b0;
    end
  end

  // Compare process: FIFO view, flags and pulse widths on every cycle.
  always @(negedge PCLK) begin
    if (PRESETn) begin
      check("fifo_level", 32'(bus.fifo_level), m_q.size());
      check("fifo_empty", 32'(bus.fifo_empty), 32'(m_q.size() == 0));
      check("fifo_full", 32'(bus.fifo_full), 32'(m_q.size() == FIFO_DEPTH));
      check("fifo_rdata", 32'(bus.fifo_rdata), (m_q.size() == 0) ? 32'd0 : 32'(m_q[0]));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("timeout_err", 32'(timeout_err), 32'(m_tmo));
      check("start_conv_width", 32'(bus.start_conv && sc_prev), 32'd0);
      check("scan_done_width", 32'(scan_done && sd_prev), 32'd0);
      if (scan_done) done_cnt++;
      sc_prev = bus.start_conv;
      sd_prev = scan_done;
    end else begin
      sc_prev = 1'b0;
      sd_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic pulse_start(output int c0);
    scan_start = 1'b1;
    c0 = cyc;
    tick();
    scan_start = 1'b0;
  endtask

  // Wait (bounded) for start_conv; check its cycle and the channel/gain shown.
  task automatic wait_start(input logic [1:0] ch, input int exp_c, output int c);
    c = -1;
    for (int i = 0; i < 300 && c < 0; i++) begin
      if (bus.start_conv) c = cyc;
      else tick();
    end
    check("start_conv_cycle", c, exp_c);
    check("channel_sel", 32'(bus.channel_sel), 32'(ch));
    check("pga_gain", 32'(bus.pga_gain), 32'(gain_cfg[2*int'(ch) +: 2]));
  endtask

  // One conversion: wait for the start, answer after dly cycles of WAIT_CONV.
  task automatic convert(input logic [1:0] ch, input int exp_c, input logic [15:0] data,
                         input int dly, input bit rd, input bit drop_en, output int t);
    int c;
    wait_start(ch, exp_c, c);
    m_ch = ch;
    tick();
    if (drop_en) scan_en = 1'b0;
    repeat (dly) tick();
    bus.sar_valid = 1'b1;
    bus.sar_data  = data;
    bus.fifo_rd   = rd;
    t = cyc;
    tick();
    bus.sar_valid = 1'b0;
    bus.fifo_rd   = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      bus.fifo_rd = 1'b1;
      tick();
    end
    bus.fifo_rd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int c0, c, t, t2, d0;
    scan_en = 1'b1; scan_start = 1'b0; continuous = 1'b0; err_clr = 1'b0;
    ch_mask = 3'b000; gain_cfg = 6'b0; settle_cycles = 8'd0;
    bus.sar_busy = 1'b0; bus.sar_valid = 1'b0; bus.sar_data = '0; bus.fifo_rd = 1'b0;

    // Reset values
    #12;
    check("rst_empty", 32'(bus.fifo_empty), 32'd1);
    check("rst_level", 32'(bus.fifo_level), 32'd0);
    check("rst_rdata", 32'(bus.fifo_rdata), 32'd0);
    check("rst_active", 32'(scan_active), 32'd0);
    check("rst_start", 32'(bus.start_conv), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    tick();

    // Empty mask: scan_start ignored
    pulse_start(c0);
    repeat (4) tick();
    check("zero_mask_idle", 32'(scan_active), 32'd0);

    // Test 1: mask 101, settle 0, one-shot
    ch_mask = 3'b101; gain_cfg = 6'b11_00_10; settle_cycles = 8'd0;
    d0 = done_cnt;
    pulse_start(c0);
    convert(2'd0, c0 + 3, 16'h1234, 2, 1'b0, 1'b0, t);
    check("t1_gain0", 32'(bus.pga_gain), 32'd2);
    convert(2'd2, t + 4, 16'hABCD, 1, 1'b0, 1'b0, t2);
    check("t1_gain2", 32'(bus.pga_gain), 32'd3);
    tick();
    check("t1_done", 32'(scan_done), 32'd1);
    check("t1_active", 32'(scan_active), 32'd0);
    tick();
    check("t1_done_cnt", done_cnt - d0, 32'd1);
    check("t1_head0", 32'(bus.fifo_rdata), 32'h0_1234);
    check("t1_level", 32'(bus.fifo_level), 32'd2);
    drain(1);
    check("t1_head1", 32'(bus.fifo_rdata), 32'h2_ABCD);
    drain(1);
    check("t1_empty", 32'(bus.fifo_empty), 32'd1);

    // Test 2: continuous 111, fill, overrun, swap on full
    ch_mask = 3'b111; continuous = 1'b1; gain_cfg = 6'b01_10_11;
    d0 = done_cnt;
    pulse_start(c0);
    t = c0 - 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        err_clr = 1'b1; tick(); err_clr = 1'b0;
      end
      convert(2'(i % 3), (i == 0) ? c0 + 3 : t + 4, 16'h1000 + 16'(i), 1, (i == 9), 1'b0, t);
      if (i == 7) begin
        check("t2_full", 32'(bus.fifo_full), 32'd1);
        check("t2_level8", 32'(bus.fifo_level), 32'd8);
      end
      if (i == 8) begin
        check("t2_overrun", 32'(overrun), 32'd1);
        check("t2_head_kept", 32'(bus.fifo_rdata), 32'h0_1000);
      end
      if (i == 9) begin
        check("t2_no_overrun", 32'(overrun), 32'd0);
        check("t2_swap_level", 32'(bus.fifo_level), 32'd8);
        check("t2_swap_head", 32'(bus.fifo_rdata), 32'h1_1001);
        scan_en = 1'b0;
        continuous = 1'b0;
      end
    end
    repeat (3) tick();
    check("t2_idle", 32'(scan_active), 32'd0);
    check("t2_done_cnt", done_cnt - d0, 32'd3);
    drain(8);
    check("t2_drained", 32'(bus.fifo_level), 32'd0);
    scan_en = 1'b1;

    // Test 3: SAR busy for 5 cycles on entry to START
    ch_mask = 3'b001; settle_cycles = 8'd2;
    bus.sar_busy = 1'b1;
    pulse_start(c0);
    while (cyc < c0 + 10) begin
      check("t3_held", 32'(bus.start_conv), 32'd0);
      tick();
    end
    bus.sar_busy = 1'b0;
    convert(2'd0, c0 + 11, 16'h5A5A, 0, 1'b0, 1'b0, t);
    repeat (3) tick();
    check("t3_head", 32'(bus.fifo_rdata), 32'h0_5A5A);
    drain(1);

    // Test 4: scan_en dropped in WAIT_CONV of channel 0
    ch_mask = 3'b111; settle_cycles = 8'd1;
    d0 = done_cnt;
    pulse_start(c0);
    convert(2'd0, c0 + 4, 16'hBEEF, 2, 1'b0, 1'b1, t);
    repeat (40) begin
      check("t4_no_start", 32'(bus.start_conv), 32'd0);
      check("t4_chsel", 32'(bus.channel_sel), 32'd0);
      tick();
    end
    check("t4_idle", 32'(scan_active), 32'd0);
    check("t4_no_done", done_cnt - d0, 32'd0);
    check("t4_head", 32'(bus.fifo_rdata), 32'h0_BEEF);
    drain(1);
    scan_en = 1'b1;

    // Test 5: reset in SETTLE with 3 entries present
    ch_mask = 3'b111; settle_cycles = 8'd0;
    pulse_start(c0);
    convert(2'd0, c0 + 3, 16'h0111, 1, 1'b0, 1'b0, t);
    convert(2'd1, t + 4, 16'h0222, 0, 1'b0, 1'b0, t);
    convert(2'd2, t + 4, 16'h0333, 3, 1'b0, 1'b0, t);
    repeat (3) tick();
    check("t5_level3", 32'(bus.fifo_level), 32'd3);
    ch_mask = 3'b110; settle_cycles = 8'd6;
    pulse_start(c0);
    tick();
    tick();
    check("t5_pre_chsel", 32'(bus.channel_sel), 32'd1);
    PRESETn = 1'b0;
    #2;
    check("t5_level", 32'(bus.fifo_level), 32'd0);
    check("t5_empty", 32'(bus.fifo_empty), 32'd1);
    check("t5_full", 32'(bus.fifo_full), 32'd0);
    check("t5_rdata", 32'(bus.fifo_rdata), 32'd0);
    check("t5_active", 32'(scan_active), 32'd0);
    check("t5_chsel", 32'(bus.channel_sel), 32'd0);
    check("t5_gain", 32'(bus.pga_gain), 32'd0);
    check("t5_start", 32'(bus.start_conv), 32'd0);
    check("t5_done", 32'(scan_done), 32'd0);
    check("t5_overrun", 32'(overrun), 32'd0);
    #1;
    PRESETn = 1'b1;
    repeat (20) begin
      tick();
      check("t5_stay_idle", 32'(scan_active), 32'd0);
      check("t5_no_start", 32'(bus.start_conv), 32'd0);
    end

`ifdef ADC_SCAN_TIMEOUT_EN
    // Test 6: watchdog
    ch_mask = 3'b001; settle_cycles = 8'd0;
    d0 = done_cnt;
    pulse_start(c0);
    wait_start(2'd0, c0 + 3, c);
    tmo_at = c + 16;
    while (cyc < c + 17) tick();
    check("t6_timeout", 32'(timeout_err), 32'd1);
    check("t6_no_write", 32'(bus.fifo_level), 32'd0);
    tick();
    check("t6_done", 32'(scan_done), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tick();
    check("t6_cleared", 32'(timeout_err), 32'd0);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
